// File: rtl/fios_seq_stream.sv
// fios_seq_stream: pass-level operation sequencer for FIOS Montgomery multipliers.
// Accepts a start request, runs NB_PASS passes of PASS_LEN cycles each driving
// PE start / operand fetch / a-shift control, then collects S result words from
// the core into a first-word-fall-through FIFO that drains downstream.
// Optional feature macro: FIOS_SEQ_TIMEOUT_EN enables a COLLECT-state watchdog
// (TIMEOUT cycles without a push flushes the FIFO, flags err_o, returns to IDLE).
// All outputs come straight from flops; their next values are derived from the
// next-state values so that they line up with the state they describe.
module fios_seq_stream #(
    parameter int W          = 17,
    parameter int S          = 8,
    parameter int PE_NB      = 3,
    parameter int PE_DELAY   = 6,
    parameter int LOOP_DELAY = 0,
    parameter int TIMEOUT    = 1024,
    localparam int NB_PASS   = (S + PE_NB - 1) / PE_NB,
    localparam int AW        = (S > 1) ? $clog2(S) : 1,
    localparam int PW        = $clog2(NB_PASS + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          start_ready_o,
    output logic          pe_start_o,
    output logic          b_fetch_o,
    output logic          p_fetch_o,
    output logic [AW-1:0] op_addr_o,
    output logic          a_shift_o,
    output logic [PW-1:0] pass_idx_o,
    input  logic [W-1:0]  core_res_i,
    input  logic          core_res_push_i,
    output logic [W-1:0]  res_data_o,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic          done_o,
    output logic          err_o
);

    localparam int PE_SPAN  = PE_NB * PE_DELAY + LOOP_DELAY;
    localparam int PASS_LEN = (S > PE_SPAN) ? S : PE_SPAN;
    localparam int CW       = $clog2(PASS_LEN + 1);
    localparam int NW       = $clog2(S + 1);

    localparam logic [CW-1:0] LAST_CYC  = CW'(PASS_LEN - 1);
    localparam logic [CW-1:0] S_CYC     = CW'(S);
    localparam logic [PW-1:0] LAST_PASS = PW'(NB_PASS - 1);
    localparam logic [NW-1:0] S_CNT     = NW'(S);
    localparam logic [NW-1:0] LAST_CNT  = NW'(S - 1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(S - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_COLLECT = 2'd2
    } state_t;

    // control state
    state_t        state_q, state_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [NW-1:0] rx_q, rx_d;

    // FIFO state
    logic [W-1:0]  mem_q [S];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] pop_cnt_q, pop_cnt_d;

    // registered outputs
    logic          start_ready_q, start_ready_d;
    logic          pe_start_q, pe_start_d;
    logic          fetch_q, fetch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          a_shift_q, a_shift_d;
    logic [PW-1:0] pass_idx_q, pass_idx_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // handshake / push qualification
    logic pop, push, push_coll, full, stray, overflow;
    logic timeout;

`ifdef FIOS_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wd_q, wd_d;

    // Watchdog: counts COLLECT cycles, restarts on every push, fires on the TIMEOUT-th cycle
    always_comb begin
        timeout = (state_q == ST_COLLECT) && (wd_q == WD_LAST);
        if ((state_q != ST_COLLECT) || core_res_push_i || timeout) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + TW'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    // No watchdog: COLLECT waits for the core indefinitely (expression is constant 0)
    assign timeout = (TIMEOUT < 0);
`endif

    // Push/pop qualification; a push on the timeout cycle loses to the flush
    always_comb begin
        pop       = res_valid_q && res_ready_i;
        full      = (cnt_q == S_CNT);
        push_coll = core_res_push_i && (state_q == ST_COLLECT) && !timeout;
        push      = push_coll && (!full || pop);
        overflow  = push_coll && full && !pop;
        stray     = core_res_push_i && (state_q != ST_COLLECT);
    end

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            cyc_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cyc_q   <= cyc_d;
            rx_q    <= rx_d;
        end
    end

    // FSM next state: pass/cycle walk in RUN, result word count in COLLECT
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        cyc_d   = cyc_q;
        rx_d    = rx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && start_ready_q) begin
                    state_d = ST_RUN;
                    pass_d  = '0;
                    cyc_d   = '0;
                end
            end
            ST_RUN: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    if (pass_q == LAST_PASS) begin
                        state_d = ST_COLLECT;
                        pass_d  = '0;
                        rx_d    = '0;
                    end else begin
                        pass_d = pass_q + PW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_COLLECT: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                    rx_d    = '0;
                end else if (push) begin
                    if (rx_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        rx_d    = '0;
                    end else begin
                        rx_d = rx_q + NW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pass_d  = '0;
                cyc_d   = '0;
                rx_d    = '0;
            end
        endcase
    end

    // FSM outputs, derived from the next state so the registered copy matches it
    always_comb begin
        start_ready_d = (state_d == ST_IDLE) && (cnt_d == '0);
        pe_start_d    = 1'b0;
        fetch_d       = 1'b0;
        addr_d        = '0;
        a_shift_d     = 1'b0;
        pass_idx_d    = '0;
        if (state_d == ST_RUN) begin
            pe_start_d = (cyc_d == '0);
            fetch_d    = (cyc_d < S_CYC);
            addr_d     = fetch_d ? cyc_d[AW-1:0] : '0;
            a_shift_d  = (cyc_d == LAST_CYC) && (pass_d != LAST_PASS);
            pass_idx_d = pass_d;
        end
    end

    // FIFO pointers, occupancy, fall-through head, done and sticky error
    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        pop_cnt_d = pop_cnt_q;
        done_d    = 1'b0;
        if (timeout) begin
            wr_d      = '0;
            rd_d      = '0;
            cnt_d     = '0;
            pop_cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + AW'(1);
                if (pop_cnt_q == LAST_CNT) begin
                    done_d    = 1'b1;
                    pop_cnt_d = '0;
                end else begin
                    pop_cnt_d = pop_cnt_q + NW'(1);
                end
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + NW'(1);
                2'b01:   cnt_d = cnt_q - NW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        // The word being written lands at the new head only when the FIFO is
        // (or becomes) empty apart from it; otherwise the head is already stored.
        res_data_d  = (push && (wr_q == rd_d)) ? core_res_i : mem_q[rd_d];
        res_valid_d = (cnt_d != '0);
        err_d       = err_q || stray || overflow || timeout;
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_q] <= core_res_i;
        end
    end

    // FIFO bookkeeping and output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            pop_cnt_q     <= '0;
            start_ready_q <= 1'b1;
            pe_start_q    <= 1'b0;
            fetch_q       <= 1'b0;
            addr_q        <= '0;
            a_shift_q     <= 1'b0;
            pass_idx_q    <= '0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            start_ready_q <= start_ready_d;
            pe_start_q    <= pe_start_d;
            fetch_q       <= fetch_d;
            addr_q        <= addr_d;
            a_shift_q     <= a_shift_d;
            pass_idx_q    <= pass_idx_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign start_ready_o = start_ready_q;
    assign pe_start_o    = pe_start_q;
    assign b_fetch_o     = fetch_q;
    assign p_fetch_o     = fetch_q;
    assign op_addr_o     = addr_q;
    assign a_shift_o     = a_shift_q;
    assign pass_idx_o    = pass_idx_q;
    assign res_data_o    = res_data_q;
    assign res_valid_o   = res_valid_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fios_seq_stream.sv
// Bench for fios_seq_stream: default instance checked every cycle against a
// spec-level model (pass schedule by arithmetic on the cycle number, FIFO as a
// queue), a schedule vector table, hand sequences for backpressure / errors /
// reset, a single-pass instance (PE_NB=8) and, with FIOS_SEQ_TIMEOUT_EN, a
// TIMEOUT=16 instance. done_o and start_ready_o are registered, so both show
// up in the cycle after the handshake that pops the last word.
module tb_fios_seq_stream;

    localparam int W    = 17;
    localparam int S    = 8;
    localparam int NB   = 3;   // ceil(8/3)
    localparam int PL   = 18;  // max(8, 3*6+0)
    localparam int RUNC = NB * PL;

    logic clk;
    logic reset_i;

    // default instance
    logic          start_i, core_res_push_i, res_ready_i;
    logic [W-1:0]  core_res_i;
    logic          start_ready_o, pe_start_o, b_fetch_o, p_fetch_o, a_shift_o;
    logic [2:0]    op_addr_o;
    logic [1:0]    pass_idx_o;
    logic [W-1:0]  res_data_o;
    logic          res_valid_o, done_o, err_o;

    fios_seq_stream u_dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .start_ready_o(start_ready_o),
        .pe_start_o(pe_start_o), .b_fetch_o(b_fetch_o), .p_fetch_o(p_fetch_o),
        .op_addr_o(op_addr_o), .a_shift_o(a_shift_o), .pass_idx_o(pass_idx_o),
        .core_res_i(core_res_i), .core_res_push_i(core_res_push_i),
        .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .done_o(done_o), .err_o(err_o)
    );

    // single-pass instance: PE_NB=8 -> NB_PASS=1, PASS_LEN=48
    logic          s8_start, s8_push;
    logic [W-1:0]  s8_data;
    logic          s8_sr, s8_pe, s8_bf, s8_pf, s8_ash, s8_valid, s8_done, s8_err;
    logic [2:0]    s8_addr;
    logic [0:0]    s8_pidx;
    logic [W-1:0]  s8_rdata;

    fios_seq_stream #(.PE_NB(8)) u_dut8 (
        .clock_i(clk), .reset_i(reset_i), .start_i(s8_start), .start_ready_o(s8_sr),
        .pe_start_o(s8_pe), .b_fetch_o(s8_bf), .p_fetch_o(s8_pf),
        .op_addr_o(s8_addr), .a_shift_o(s8_ash), .pass_idx_o(s8_pidx),
        .core_res_i(s8_data), .core_res_push_i(s8_push),
        .res_data_o(s8_rdata), .res_valid_o(s8_valid), .res_ready_i(1'b0),
        .done_o(s8_done), .err_o(s8_err)
    );

`ifdef FIOS_SEQ_TIMEOUT_EN
    logic          to_start, to_push, to_ready;
    logic [W-1:0]  to_data;
    logic          to_sr, to_pe, to_bf, to_pf, to_ash, to_valid, to_done, to_err;
    logic [2:0]    to_addr;
    logic [1:0]    to_pidx;
    logic [W-1:0]  to_rdata;

    fios_seq_stream #(.TIMEOUT(16)) u_dut_to (
        .clock_i(clk), .reset_i(reset_i), .start_i(to_start), .start_ready_o(to_sr),
        .pe_start_o(to_pe), .b_fetch_o(to_bf), .p_fetch_o(to_pf),
        .op_addr_o(to_addr), .a_shift_o(to_ash), .pass_idx_o(to_pidx),
        .core_res_i(to_data), .core_res_push_i(to_push),
        .res_data_o(to_rdata), .res_valid_o(to_valid), .res_ready_i(to_ready),
        .done_o(to_done), .err_o(to_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec-level) ----------------
    int           m_state;   // 0 idle, 1 run, 2 collect
    int           run_k;     // 1-based cycle number inside RUN
    int           rx;
    int           pops;
    logic         m_done;
    logic         m_err;
    logic [W-1:0] q[$];

    task automatic model_clear();
        m_state = 0; run_k = 0; rx = 0; pops = 0; m_done = 0; m_err = 0;
        q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs to the default instance, advance the model,
    // then compare every output after the edge.
    task automatic drive_cycle(input logic st, input logic ps, input logic [W-1:0] dat,
                               input logic rdy);
        int   pre, c, p;
        logic sr, do_pop;
        logic e_pe, e_f, e_ash;
        int   e_addr, e_pidx;
        logic [W-1:0] tmp;
        start_i = st; core_res_push_i = ps; core_res_i = dat; res_ready_i = rdy;
        pre    = m_state;
        sr     = (pre == 0) && (q.size() == 0);
        do_pop = rdy && (q.size() > 0);
        m_done = 1'b0;
        if (do_pop) begin
            tmp = q.pop_front();
            pops++;
            if (pops == S) begin m_done = 1'b1; pops = 0; end
        end
        if (ps) begin
            if (pre == 2) begin
                if (q.size() == S) m_err = 1'b1;
                else begin
                    q.push_back(dat);
                    rx++;
                    if (rx == S) begin m_state = 0; rx = 0; end
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (pre == 1) begin
            if (run_k == RUNC) m_state = 2;
            else run_k++;
        end
        if (pre == 0 && st && sr) begin m_state = 1; run_k = 1; end
        tick();
        start_i = 1'b0; core_res_push_i = 1'b0;
        e_pe = 0; e_f = 0; e_ash = 0; e_addr = 0; e_pidx = 0;
        if (m_state == 1) begin
            c = (run_k - 1) % PL;
            p = (run_k - 1) / PL;
            e_pe   = (c == 0);
            e_f    = (c < S);
            e_addr = e_f ? c : 0;
            e_ash  = (c == PL - 1) && (p < NB - 1);
            e_pidx = p;
        end
        chk("start_ready", start_ready_o, (m_state == 0) && (q.size() == 0));
        chk("pe_start", pe_start_o, e_pe);
        chk("b_fetch", b_fetch_o, e_f);
        chk("p_fetch", p_fetch_o, e_f);
        chk("op_addr", op_addr_o, e_addr);
        chk("a_shift", a_shift_o, e_ash);
        chk("pass_idx", pass_idx_o, e_pidx);
        chk("res_valid", res_valid_o, q.size() > 0);
        if (q.size() > 0) chk("res_data", res_data_o, q[0]);
        chk("done", done_o, m_done);
        chk("err", err_o, m_err);
    endtask

    task automatic do_reset(input int cycles);
        reset_i = 1'b1;
        start_i = 0; core_res_push_i = 0; core_res_i = '0; res_ready_i = 0;
        s8_start = 0; s8_push = 0; s8_data = '0;
`ifdef FIOS_SEQ_TIMEOUT_EN
        to_start = 0; to_push = 0; to_data = '0; to_ready = 0;
`endif
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_start_ready", start_ready_o, 1'b1);
        chk("rst_pe_start", pe_start_o, 1'b0);
        chk("rst_b_fetch", b_fetch_o, 1'b0);
        chk("rst_p_fetch", p_fetch_o, 1'b0);
        chk("rst_op_addr", op_addr_o, 0);
        chk("rst_a_shift", a_shift_o, 1'b0);
        chk("rst_pass_idx", pass_idx_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_res_valid", res_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        reset_i = 1'b0;
        model_clear();
    endtask

    // ---------------- schedule vector table ----------------
    typedef struct {
        int   k;
        logic pe;
        logic f;
        int   addr;
        logic ash;
        int   pidx;
    } vec_t;

    vec_t tbl[12];

    task automatic tbl_check(input int k);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].k == k) begin
                chk($sformatf("tbl%0d_pe_start", k), pe_start_o, tbl[i].pe);
                chk($sformatf("tbl%0d_fetch", k), b_fetch_o, tbl[i].f);
                chk($sformatf("tbl%0d_addr", k), op_addr_o, tbl[i].addr);
                chk($sformatf("tbl%0d_a_shift", k), a_shift_o, tbl[i].ash);
                chk($sformatf("tbl%0d_pass_idx", k), pass_idx_o, tbl[i].pidx);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1,  1'b1, 1'b1, 0, 1'b0, 0};
        tbl[1]  = '{8,  1'b0, 1'b1, 7, 1'b0, 0};
        tbl[2]  = '{9,  1'b0, 1'b0, 0, 1'b0, 0};
        tbl[3]  = '{18, 1'b0, 1'b0, 0, 1'b1, 0};
        tbl[4]  = '{19, 1'b1, 1'b1, 0, 1'b0, 1};
        tbl[5]  = '{26, 1'b0, 1'b1, 7, 1'b0, 1};
        tbl[6]  = '{27, 1'b0, 1'b0, 0, 1'b0, 1};
        tbl[7]  = '{36, 1'b0, 1'b0, 0, 1'b1, 1};
        tbl[8]  = '{37, 1'b1, 1'b1, 0, 1'b0, 2};
        tbl[9]  = '{44, 1'b0, 1'b1, 7, 1'b0, 2};
        tbl[10] = '{54, 1'b0, 1'b0, 0, 1'b0, 2};
        tbl[11] = '{55, 1'b0, 1'b0, 0, 1'b0, 0};

        model_clear();
        do_reset(3);

        // pass schedule, start accepted in cycle 0
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        tbl_check(1);
        for (int k = 2; k <= 55; k++) begin
            drive_cycle(1'b0, 1'b0, '0, 1'b1);
            tbl_check(k);
        end

        // 8 words 1..8 with the sink always ready, then drain
        for (int i = 1; i <= 8; i++) drive_cycle(1'b0, 1'b1, W'(i), 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b0, '0, 1'b1);

        // backpressure: FIFO fills, start ignored while holding, accepted after drain
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        repeat (RUNC) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, W'(17'h100 + i), 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, '0, 1'b0);
        repeat (10) drive_cycle(1'b0, 1'b0, '0, 1'b1);
        chk("hold_start_not_queued", start_ready_o, 1'b1);
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        chk("post_drain_accept", pe_start_o, 1'b1);

        // stray push in RUN sets err, then a mid-RUN reset clears everything
        do_reset(1);
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        repeat (8) drive_cycle(1'b0, 1'b0, '0, 1'b1);
        drive_cycle(1'b0, 1'b1, 17'h1ABCD, 1'b1);
        chk("stray_run_err", err_o, 1'b1);
        do_reset(1);

        // overflow: 9th push while full and not popping is dropped and flags err
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        repeat (RUNC) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) drive_cycle(1'b0, 1'b1, W'(17'h0F000 + i), 1'b0);
        chk("full_no_err", err_o, 1'b0);
        drive_cycle(1'b0, 1'b1, 17'h0DEAD, 1'b0);
        chk("overflow_err", err_o, 1'b1);
        repeat (10) drive_cycle(1'b0, 1'b0, '0, 1'b1);
        chk("overflow_drained", res_valid_o, 1'b0);

        // randomized traffic against the model
        do_reset(1);
        for (int c = 0; c < 900; c++) begin
            logic st, ps, rd;
            st = ($urandom_range(0, 3) == 0);
            ps = (m_state == 2) && ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 9) < 7);
            drive_cycle(st, ps, W'($urandom), rd);
        end

        // reset at cycle 10 of RUN returns all outputs to reset values
        do_reset(1);
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        repeat (9) drive_cycle(1'b0, 1'b0, '0, 1'b1);
        chk("run10_pe_idle", pass_idx_o, 0);
        do_reset(1);

        // single-pass instance: NB_PASS=1, PASS_LEN=48, COLLECT from cycle 49
        s8_start = 1'b1;
        tick();
        s8_start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            chk($sformatf("pe8_start_c%0d", k), s8_pe, k == 1);
            chk($sformatf("pe8_fetch_c%0d", k), s8_bf, k <= 8);
            chk($sformatf("pe8_addr_c%0d", k), s8_addr, (k <= 8) ? k - 1 : 0);
            chk($sformatf("pe8_a_shift_c%0d", k), s8_ash, 1'b0);
            chk($sformatf("pe8_ready_c%0d", k), s8_sr, 1'b0);
            chk($sformatf("pe8_err_c%0d", k), s8_err, k >= 49);
            chk($sformatf("pe8_valid_c%0d", k), s8_valid, k >= 50);
            s8_push = (k == 48) || (k == 49);
            s8_data = (k == 49) ? 17'h05555 : 17'h0AAAA;
            tick();
            s8_push = 1'b0;
        end
        chk("pe8_collect_word", s8_rdata, 17'h05555);

`ifdef FIOS_SEQ_TIMEOUT_EN
        // watchdog: 3 pushes, err 16 cycles after the last one, FIFO flushed, IDLE
        do_reset(1);
        to_start = 1'b1;
        tick();
        to_start = 1'b0;
        repeat (RUNC) tick();
        for (int i = 0; i < 3; i++) begin
            to_push = 1'b1;
            to_data = W'(17'h00300 + i);
            tick();
        end
        to_push = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        chk("to_err_before", to_err, 1'b0);
        chk("to_valid_before", to_valid, 1'b1);
        chk("to_ready_before", to_sr, 1'b0);
        tick();
        chk("to_err_after", to_err, 1'b1);
        chk("to_valid_after", to_valid, 1'b0);
        chk("to_ready_after", to_sr, 1'b1);
        to_start = 1'b1;
        tick();
        to_start = 1'b0;
        chk("to_restart_pe", to_pe, 1'b1);
        do_reset(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
